// File: rtl/stage_buffer_reg_if.sv
// stage_buffer_reg_if
//   Bus bundle for a pipeline stage register.
//   Signals:
//     in          [SIZE] data to capture (driven by upstream stage)
//     writeEnable        1 = capture on next rising edge, 0 = hold
//     out         [SIZE] registered stage contents
//     loaded             1 once a write has occurred since the last flush
//     parity_err         only when STAGE_BUFFER_PARITY_EN is defined
//   Modports:
//     master : upstream/downstream side (drives in/writeEnable)
//     slave  : the stage register itself
interface stage_buffer_reg_if #(
  parameter int unsigned SIZE = 32
);
  logic [SIZE-1:0] in;
  logic            writeEnable;
  logic [SIZE-1:0] out;
  logic            loaded;
`ifdef STAGE_BUFFER_PARITY_EN
  logic            parity_err;
`endif

  modport master (
    output in,
    output writeEnable,
    input  out,
    input  loaded
`ifdef STAGE_BUFFER_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  in,
    input  writeEnable,
    output out,
    output loaded
`ifdef STAGE_BUFFER_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/stage_buffer_reg.sv
// stage_buffer_reg
//   Write-enabled pipeline stage register (e.g. IF/ID: {PC+2, instruction}).
//   Captures bus.in on the rising clk edge when bus.writeEnable=1, holds
//   otherwise. flush (active-low, asynchronous) forces out=RESET_VALUE and
//   loaded=0. loaded lets downstream logic tell a bubble from real data.
//   Ports:
//     clk    rising-edge clock
//     flush  asynchronous active-low flush
//     bus    stage_buffer_reg_if.slave (in, writeEnable, out, loaded
//            [, parity_err])
//   Optional feature macro: STAGE_BUFFER_PARITY_EN
//     Stores the XOR of each captured word; parity_err flags a mismatch
//     between the XOR of out and the stored bit.
module stage_buffer_reg #(
  parameter int unsigned      SIZE        = 32,
  parameter logic [SIZE-1:0]  RESET_VALUE = '0
) (
  input logic                 clk,
  input logic                 flush,
  stage_buffer_reg_if.slave   bus
);

  logic [SIZE-1:0] out_q;
  logic            loaded_q;

  always_ff @(posedge clk or negedge flush) begin
    if (!flush) begin
      out_q    <= RESET_VALUE;
      loaded_q <= 1'b0;
    end else if (bus.writeEnable) begin
      out_q    <= bus.in;
      loaded_q <= 1'b1;
    end
  end

  assign bus.out    = out_q;
  assign bus.loaded = loaded_q;

`ifdef STAGE_BUFFER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge flush) begin
    if (!flush) begin
      par_q <= ^RESET_VALUE;
    end else if (bus.writeEnable) begin
      par_q <= ^bus.in;
    end
  end

  // Check against the bus value so a corrupted out is caught.
  assign bus.parity_err = (^bus.out) != par_q;
`endif

endmodule

// File: tb/tb_stage_buffer_reg.sv
module tb_stage_buffer_reg;

  localparam int unsigned SIZE = 32;

  logic clk;
  logic flush;

  stage_buffer_reg_if #(.SIZE(SIZE)) dut_if ();

  stage_buffer_reg #(
    .SIZE        (SIZE),
    .RESET_VALUE ('0)
  ) dut (
    .clk   (clk),
    .flush (flush),
    .bus   (dut_if.slave)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state and scoreboard of expected {loaded, out}.
  logic [SIZE-1:0] m_out;
  logic            m_loaded;
  logic [SIZE:0]   sb[$];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_flush();
    m_out    = '0;
    m_loaded = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [SIZE:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check(tag, {31'd0, dut_if.loaded, dut_if.out}, {31'd0, e});
    end
`ifdef STAGE_BUFFER_PARITY_EN
    check({tag, "_par"}, {63'd0, dut_if.parity_err}, 64'd0);
`endif
  endtask

  // Drive one cycle at the falling edge, predict, check 1 time unit after
  // the next rising edge.
  task automatic step(input string tag, input logic we, input logic [SIZE-1:0] d);
    @(negedge clk);
    dut_if.writeEnable = we;
    dut_if.in          = d;
    if (we) begin
      m_out    = d;
      m_loaded = 1'b1;
    end
    sb.push_back({m_loaded, m_out});
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    flush              = 1'b0;
    dut_if.writeEnable = 1'b0;
    dut_if.in          = '0;
    model_flush();

    // Asynchronous flush state before any clock edge.
    #1;
    sb.push_back({m_loaded, m_out});
    pop_check("reset_t1");
    #7 flush = 1'b1;                 // t=8
    @(posedge clk); #1;              // edge t=10, writeEnable=0
    sb.push_back({m_loaded, m_out});
    pop_check("release_no_load");

    step("hold_empty_a", 1'b0, 32'habab_abab);
    step("hold_empty_b", 1'b0, 32'hdddd_abab);
    step("first_write",  1'b1, 32'habab_ab46);
    step("hold_after_w", 1'b0, 32'hffff_ab78);
    step("consec_1",     1'b1, 32'habab_a45b);
    step("consec_2",     1'b1, 32'hdada_789b);
    step("consec_3",     1'b1, 32'h1278_aba1);
    step("hold_consec",  1'b0, 32'habab_9876);

    // in changing between edges with writeEnable=1 must not reach out early.
    @(negedge clk);
    dut_if.writeEnable = 1'b1;
    dut_if.in          = 32'h5555_aaaa;
    #3;
    sb.push_back({m_loaded, m_out});
    pop_check("no_comb_path");
    dut_if.writeEnable = 1'b0;

    // Mid-cycle flush pulse clears immediately, before any clock edge.
    @(posedge clk); #3;
    flush = 1'b0;
    model_flush();
    #1;
    sb.push_back({m_loaded, m_out});
    pop_check("midcycle_flush");
    #2 flush = 1'b1;
    step("load_after_flush", 1'b1, 32'hcafe_0123);

    // Flush held low across an edge beats writeEnable=1.
    @(negedge clk);
    dut_if.writeEnable = 1'b1;
    dut_if.in          = 32'hdead_beef;
    flush              = 1'b0;
    model_flush();
    @(posedge clk); #1;
    sb.push_back({m_loaded, m_out});
    pop_check("flush_priority");
    #2 flush = 1'b1;
    @(negedge clk); dut_if.writeEnable = 1'b0;
    @(posedge clk); #1;
    sb.push_back({m_loaded, m_out});
    pop_check("release_no_capture");

    // Boundary patterns and random traffic.
    step("all_ones",  1'b1, '1);
    step("all_zeros", 1'b1, '0);
    step("msb_only",  1'b1, 32'h8000_0000);
    for (int i = 0; i < 24; i++) begin
      step("random", 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef STAGE_BUFFER_PARITY_EN
    begin
      logic b;
      @(negedge clk);
      dut_if.writeEnable = 1'b0;
      b = dut_if.out[5];
      force dut_if.out[5] = ~b;
      #1;
      check("parity_fault", {63'd0, dut_if.parity_err}, 64'd1);
      release dut_if.out[5];
      #1;
      check("parity_clear", {63'd0, dut_if.parity_err}, 64'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_buffer_reg.md
Name: stage_buffer_reg

Overview:
- Parameterised, write-enabled pipeline stage register placed between CPU pipeline stages (e.g. IF/ID: {PC+2, instruction}).
- Captures a SIZE-bit word on the rising clock edge when write is enabled and holds it otherwise.
- Active-low asynchronous flush clears the stage to RESET_VALUE.
- Provides a stage-valid flag so downstream logic can distinguish a bubble from real data.

Parameters:
- SIZE, 32, data width in bits (1..1024).
- RESET_VALUE, {SIZE{1'b0}}, value loaded into out on flush.

Ports:
- clk  input  1  rising-edge clock.
- flush  input  1  asynchronous, active-low reset/flush; 0 clears the stage.
- in  input  SIZE  data to capture.
- writeEnable  input  1  1 = capture in on next rising edge; 0 = hold.
- out  output  SIZE  registered stage contents.
- loaded  output  1  1 once at least one write has occurred since the last flush.
- parity_err  output  1  present only with the optional feature; see below.

Interface: one clock (clk); reset is asynchronous and active-low (flush). The polarity and synchronicity are fixed.

Behaviour:
- Flush:
  - flush=0 forces out=RESET_VALUE and loaded=0 immediately, with no clock required.
  - The values hold for as long as flush=0.
  - writeEnable is ignored while flush=0.
- Release: flush rising does not itself load data; the first capture occurs at the first rising clk edge with flush=1 and writeEnable=1.
- Capture:
  - On rising clk with flush=1 and writeEnable=1: out<=in and loaded<=1.
  - Latency is one edge. The value is visible after the edge and stable for the whole following cycle.
- Hold: on rising clk with writeEnable=0, out and loaded keep their previous values.
- Input sampling:
  - in and writeEnable are sampled only at the rising edge.
  - Changes between edges have no effect on out. out is purely registered, with no combinational path from in to out.
- Flush mid-operation: flush falling between edges clears out asynchronously. Any pending write for the next edge is lost unless flush has returned high before that edge.
- Simultaneous edges: flush=0 at a rising clk edge has priority over writeEnable=1; the result is RESET_VALUE with loaded=0.
- Bit ordering: the stage is opaque. Callers pack fields (for IF/ID, [31:16]=PC+2 and [15:0]=instruction), and out preserves bit positions exactly.
- Unknown inputs: X on writeEnable at an edge while flush=1 may yield X on out. Benches shall drive it to a known value.
- No other state exists; there is no stall counter and no bypass.

Optional Feature:
- Macro: STAGE_BUFFER_PARITY_EN.
- Defined:
  - An internal parity bit is captured with each write as the XOR of in. The stored parity on flush equals the XOR of RESET_VALUE.
  - Output parity_err = (XOR of out) != stored parity bit, evaluated combinationally. It is 0 in fault-free operation, including immediately after flush.
  - The parity bit obeys identical flush, write and hold rules.
- Not defined: the parity_err port and the parity storage are absent, and the module has exactly the other ports listed.

Test Plan (SIZE=32, RESET_VALUE=0, clk period 20, first rising edge at t=10):
- flush=0 from t=0, released at t=8; writeEnable=0 at edge t=10 -> out=0000_0000 and loaded=0 from t=0 through t=10.
- Edges with writeEnable=0 and in={abab,abab} then {dddd,abab} -> out stays 0000_0000.
- writeEnable=1, in={abab,ab46} at an edge -> out=abab_ab46 and loaded=1 after that edge. Next edge with writeEnable=0, in={ffff,ab78} -> out stays abab_ab46.
- Consecutive writes {abab,a45b}, {dada,789b}, {1278,aba1} on three edges -> out tracks abab_a45b, dada_789b, 1278_aba1 edge by edge. A following edge with writeEnable=0, in={abab,9876} -> out holds 1278_aba1.
- Mid-cycle flush pulse low (t=+3 to +6 after an edge) with out=1278_aba1 -> out=0000_0000 and loaded=0 at the flush fall, before the next edge. The next edge with writeEnable=1 loads normally.
- With STAGE_BUFFER_PARITY_EN defined, repeat the captures -> parity_err=0 throughout. Forcing one out bit flipped via a bench force -> parity_err=1.
